// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC, direct-mapped I-cache, miss fill and queue push
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INST_WIDTH   = 32,
  parameter int                    ICACHE_IDX_W = 7,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  iq_full_iq_in,
  output logic [INST_WIDTH-1:0] inst_iq_out,
  output logic [ADDR_WIDTH-1:0] pc_iq_out,
  output logic                  rdy_iq_out,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_rdy_in,
  input  logic [INST_WIDTH-1:0] mem_inst_in,
  input  logic                  refresh_rob_cdb_in,
  input  logic [ADDR_WIDTH-1:0] refresh_pc_rob_cdb_in
);
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = ADDR_WIDTH - ICACHE_IDX_W - 2;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_MISS  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_req_q, mem_req_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_arr  [LINES];
  logic [INST_WIDTH-1:0]   data_arr [LINES];

  logic [ICACHE_IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0]        tag, fill_tag;
  logic                    hit, push, fill_we;
  logic [ADDR_WIDTH-1:0]   redirect_pc;

  assign idx         = pc_q[ICACHE_IDX_W+1:2];
  assign tag         = pc_q[ADDR_WIDTH-1:ICACHE_IDX_W+2];
  // The fill always targets the line of the outstanding request, even after a redirect.
  assign fill_idx    = mem_addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag    = mem_addr_q[ADDR_WIDTH-1:ICACHE_IDX_W+2];
  assign hit         = valid_q[idx] && (tag_arr[idx] == tag);
  assign redirect_pc = refresh_pc_rob_cdb_in & ~ADDR_WIDTH'(3);
  // A redirect suppresses the push: the queue flushes itself in that cycle.
  assign push        = (state_q == S_FETCH) && hit && !iq_full_iq_in &&
                       !refresh_rob_cdb_in && rdy_in && !rst_in;
  assign fill_we     = (state_q == S_MISS) && mem_rdy_in && rdy_in;

  assign rdy_iq_out   = push;
  assign inst_iq_out  = data_arr[idx];
  assign pc_iq_out    = pc_q;
  assign mem_req_out  = mem_req_q;
  assign mem_addr_out = mem_addr_q;

  // Next-state logic: FETCH pushes hits or launches a miss; MISS waits for the fill.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    if (rdy_in) begin
      case (state_q)
        S_FETCH: begin
          if (refresh_rob_cdb_in) begin
            pc_d = redirect_pc;
          end else if (push) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
          end else if (!hit) begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = S_MISS;
          end
        end
        S_MISS: begin
          if (mem_rdy_in) begin
            valid_d[fill_idx] = 1'b1;
            mem_req_d         = 1'b0;
            state_d           = S_FETCH;
          end
          if (refresh_rob_cdb_in) begin
            pc_d = redirect_pc;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC & ~ADDR_WIDTH'(3);
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data arrays are written only by fills and are never reset.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_inst_in;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic        iq_full;
  logic [31:0] inst_iq_out;
  logic [31:0] pc_iq_out;
  logic        rdy_iq_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_rdy_in;
  logic [31:0] mem_inst_in;
  logic        refresh;
  logic [31:0] refresh_pc;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;
  int npush = 0;
  int fixed_lat = 3;

  typedef struct { int cyc; logic [31:0] pc; logic [31:0] inst; } push_t;
  typedef struct { int cyc; logic [31:0] addr; } req_t;
  push_t exp_q[$];
  req_t  req_q[$];

  inst_fetch_unit dut (
    .clk_in               (clk),
    .rst_in               (rst),
    .rdy_in               (rdy_in),
    .iq_full_iq_in        (iq_full),
    .inst_iq_out          (inst_iq_out),
    .pc_iq_out            (pc_iq_out),
    .rdy_iq_out           (rdy_iq_out),
    .mem_req_out          (mem_req_out),
    .mem_addr_out         (mem_addr_out),
    .mem_rdy_in           (mem_rdy_in),
    .mem_inst_in          (mem_inst_in),
    .refresh_rob_cdb_in   (refresh),
    .refresh_pc_rob_cdb_in(refresh_pc)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory controller: answers each request after a latency, only in enabled cycles.
  initial begin
    int cnt = 0;
    int lat = 1;
    mem_rdy_in  = 1'b0;
    mem_inst_in = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rdy_in = 1'b0;
      if (rst || !mem_req_out) begin
        cnt = 0;
      end else begin
        if (cnt == 0) lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        cnt++;
        if (cnt >= lat && rdy_in) begin
          mem_rdy_in  = 1'b1;
          mem_inst_in = memf(mem_addr_out);
        end
      end
    end
  end

  // Reference model: cache as a map from line index to the full address it holds.
  initial begin
    logic [31:0] m_pc  = '0;
    logic [31:0] m_req = '0;
    bit          m_busy = 0;
    bit          m_hit;
    logic [31:0] mcache [int];
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pc = '0;
        m_busy = 0;
        mcache.delete();
      end else if (rdy_in) begin
        if (!m_busy) begin
          m_hit = mcache.exists(int'(m_pc[8:2])) && (mcache[int'(m_pc[8:2])] == m_pc);
          if (refresh) begin
            m_pc = refresh_pc & ~32'd3;
          end else if (m_hit && !iq_full) begin
            exp_q.push_back('{cyc, m_pc, memf(m_pc)});
            m_pc = m_pc + 32'd4;
          end else if (!m_hit) begin
            m_busy = 1;
            m_req  = m_pc;
            req_q.push_back('{cyc + 1, m_pc});
          end
        end else begin
          if (mem_rdy_in) begin
            mcache[int'(m_req[8:2])] = m_req;
            m_busy = 0;
          end
          if (refresh) m_pc = refresh_pc & ~32'd3;
        end
      end
    end
  end

  // Monitor: pops expected pushes/requests when the DUT presents them.
  initial begin
    logic        prev_req  = 1'b0;
    logic [31:0] last_addr = '0;
    push_t e;
    req_t  r;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        ncmp++; nfail++;
        $display("FAIL missing_push: expected pc %h at cycle %0d did not occur", e.pc, e.cyc);
      end
      while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
        r = req_q.pop_front();
        ncmp++; nfail++;
        $display("FAIL missing_req: expected addr %h at cycle %0d did not occur", r.addr, r.cyc);
      end
      if (!rst && rdy_iq_out) begin
        npush++;
        if (exp_q.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL unexpected_push: pc %h inst %h, expected no push (cycle %0d)",
                   pc_iq_out, inst_iq_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("push_cycle", cyc, e.cyc);
          chk("push_pc", pc_iq_out, e.pc);
          chk("push_inst", inst_iq_out, e.inst);
        end
      end
      if (!rst && mem_req_out && !prev_req) begin
        if (req_q.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL unexpected_req: addr %h, expected no request (cycle %0d)", mem_addr_out, cyc);
        end else begin
          r = req_q.pop_front();
          chk("req_cycle", cyc, r.cyc);
          chk("req_addr", mem_addr_out, r.addr);
        end
      end else if (!rst && mem_req_out && prev_req) begin
        chk("req_addr_stable", mem_addr_out, last_addr);
      end
      prev_req  = mem_req_out;
      last_addr = mem_addr_out;
    end
  end

  task automatic step(input logic r, input logic f, input logic rf, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rdy_in     = r;
    iq_full    = f;
    refresh    = rf;
    refresh_pc = tgt;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!mem_req_out) break;
      step(1, 0, 0, 0);
    end
    chk("wait_idle_timeout", {31'd0, mem_req_out}, 32'd0);
  endtask

  initial begin
    logic [31:0] cap_pc, cap_addr;
    logic        cap_req;
    int          p0;
    rst = 1'b1; rdy_in = 1'b1; iq_full = 1'b0; refresh = 1'b0; refresh_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("reset_rdy_iq", {31'd0, rdy_iq_out}, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req_out}, 32'd0);
    chk("reset_mem_addr", mem_addr_out, 32'd0);
    chk("reset_pc", pc_iq_out, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold start: miss on 0x0 answered after 3 cycles, then push of 0x13.
    repeat (12) step(1, 0, 0, 0);
    fixed_lat = 0;

    // Warm the 0x0..0xC loop, then rerun it from a redirect.
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 1, 32'h0);
      repeat (40) step(1, 0, 0, 0);
    end
    wait_idle();
    step(1, 0, 1, 32'h0);
    p0 = npush;
    repeat (4) step(1, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("loop_push_count", npush - p0, 4);
    chk("loop_no_req", {31'd0, mem_req_out}, 32'd0);

    // Queue full for 5 cycles on a hit.
    step(1, 0, 1, 32'h0);
    repeat (5) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);

    // Redirect to 0x100 while a miss for 0x20 is outstanding.
    fixed_lat = 4;
    wait_idle();
    step(1, 0, 1, 32'h20);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h100);
    repeat (15) step(1, 0, 0, 0);
    fixed_lat = 0;

    // Aliasing lines: 0x000 and 0x200 share line 0.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 32'h200);
      repeat (8) step(1, 0, 0, 0);
      step(1, 0, 1, 32'h000);
      repeat (8) step(1, 0, 0, 0);
    end

    // Freeze with rdy_in low for several cycles.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    #2;
    cap_pc = pc_iq_out; cap_req = mem_req_out; cap_addr = mem_addr_out;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      @(negedge clk);
      #2;
      chk("freeze_pc", pc_iq_out, cap_pc);
      chk("freeze_req", {31'd0, mem_req_out}, {31'd0, cap_req});
      chk("freeze_addr", mem_addr_out, cap_addr);
      chk("freeze_no_push", {31'd0, rdy_iq_out}, 32'd0);
    end
    repeat (10) step(1, 0, 0, 0);

    // Randomised traffic including wrap-around and unaligned redirect targets.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] tgt;
      case ($urandom_range(0, 4))
        0:       tgt = 32'h0;
        1:       tgt = 32'h200;
        2:       tgt = 32'($urandom_range(0, 255)) * 32'd4;
        3:       tgt = 32'hFFFF_FFF0;
        default: tgt = $urandom & 32'h3FF;
      endcase
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 29) == 0, tgt);
    end

    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("drain_push_queue", exp_q.size(), 0);
    chk("drain_req_queue", req_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
